// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: start/data/stop bit receiver with a valid/ready holding register
module serial_frame_receiver #(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         s_in,
  input  logic         ready,
  output logic [N-1:0] p_out,
  output logic         valid,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0] sr;
  logic good, load;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else if (enable) state <= nxt;
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = s_in ? IDLE : DATA;
    else if (state == DATA) nxt = (cnt == CW'(N - 1)) ? STOP : DATA;
  end
  always_comb begin
    busy = state != IDLE;
    good = enable && state == STOP && s_in;
    load = good && (!valid || ready);
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt       <= '0;
      sr        <= '0;
      p_out     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (enable && state == IDLE) cnt <= '0;
      if (enable && state == DATA) begin
        cnt <= cnt + CW'(1);
        sr  <= MSB_FIRST ? {sr[N-2:0], s_in} : {s_in, sr[N-1:1]};
      end
      if (load) p_out <= sr;
      valid     <= load || (valid && !ready);
      frame_err <= enable && state == STOP && !s_in;
      overrun   <= good && valid && !ready;
    end
endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Receive end of the single-bit serial link driven by the free-running shift-register datapath.
- Hunts for a start bit on s_in, shifts in N data bits, and checks a stop bit.
- Presents each good word on a parallel port with a valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- N, 8, data bits per frame; legal range 2..32.
- MSB_FIRST, 0, 0 = first data bit after the start bit lands in p_out[0]; 1 = it lands in p_out[N-1].

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  bit strobe; s_in is sampled only on cycles with enable=1.
- s_in  input  1  serial line; idles high.
- p_out  output  N  last good received word; held while valid=1.
- valid  output  1  p_out holds an unconsumed word.
- ready  input  1  consumer accepts p_out this cycle when valid=1.
- busy  output  1  frame in progress (state DATA or STOP).
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full.

Behaviour:
- Reset (synchronous, active-high): next edge gives state=IDLE, bit counter=0, shift reg=0, p_out=0, valid=0, busy=0, frame_err=0, overrun=0. Reset wins over all other inputs. A frame in progress is discarded.
- Bit cycle: a clock edge with enable=1. On edges with enable=0, the FSM, counter and shift register hold. The valid/ready handshake still operates on every edge.
- IDLE, bit cycle with s_in=0: enter DATA, counter=0. With s_in=1: stay in IDLE.
- DATA, each bit cycle: shift s_in in according to MSB_FIRST and increment the counter. The bit cycle that captures the N-th bit moves to STOP.
- STOP, bit cycle with s_in=1 (good frame):
  - If valid=0, or valid=1 with ready=1 on the same edge: load p_out with the assembled word and set valid=1 (this is the edge after the stop bit is sampled).
  - Otherwise: drop the word, keep p_out and valid unchanged, pulse overrun for one cycle.
- STOP, bit cycle with s_in=0: drop the word and pulse frame_err for one cycle.
- STOP always returns to IDLE. The stop-bit cycle is never treated as a start bit. The earliest next start bit is the following bit cycle.
- Handshake:
  - valid=1 and ready=1 with no new load on that edge: valid clears.
  - Load and accept on the same edge: valid stays 1 and p_out takes the new word.
  - ready is ignored when valid=0.
  - p_out does not change while valid=1 except by a load on an accepting edge.
- busy=1 exactly while the state is DATA or STOP.
- Latency (enable held at 1): start bit sampled at edge t, data bits at t+1..t+N, stop bit at t+N+1, valid rises after edge t+N+1. With enable gaps, latency stretches by the number of enable=0 edges.
- Counter width is clog2(N)+1. It never wraps mid-frame because it is cleared on entry to DATA.
- frame_err and overrun are never asserted on the same cycle.

Test Plan:
- Basic frame, N=8, MSB_FIRST=0, enable=1, ready=0: s_in = 1,1,0, then 1,0,1,0,0,1,0,1, then 1 -> valid rises after the stop edge, p_out=8'hA5, busy high for 9 cycles, no error pulses.
- MSB_FIRST=1, same bit stream -> p_out=8'hA5 with the first data bit in p_out[7]; repeat with data bits 0,0,0,0,1,1,1,1 -> p_out=8'h0F.
- Enable gaps: the frame from the basic test with enable=0 on every other edge, s_in stable across gaps -> p_out=8'hA5, valid latency doubled, state held on enable=0 edges.
- Framing error: start, data 8'hFF, stop bit 0 -> frame_err high for 1 cycle, valid stays 0, p_out unchanged, FSM in IDLE. The next frame (start bit one bit cycle later) with 8'h3C is received correctly.
- Overrun and handshake:
  - Receive 8'h11 and hold ready=0; receive 8'h22 -> overrun pulse, p_out stays 8'h11.
  - Raise ready for 1 cycle -> valid drops.
  - Receive 8'h33 with ready=1 held across its stop edge -> valid=1, p_out=8'h33, no overrun.
- Reset mid-frame: assert reset for 1 cycle after 4 data bits -> all outputs 0 after the edge. The following complete frame 8'h5A is received correctly with no error pulses.
